// File: rtl/adderc_mp_seq_if.sv
// Request/response bundle for adderc_mp_seq.
// The requester uses the master modport and the sequencer uses the slave modport.
// out_ovf exists only when ADDERC_MP_SEQ_OVF_EN is defined.
interface adderc_mp_seq_if #(
    parameter int WIDTH  = 16,
    parameter int NWORDS = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NWORDS*WIDTH-1:0]  in_a;
    logic [NWORDS*WIDTH-1:0]  in_b;
    logic                     in_sub;
    logic                     in_cin;
    logic                     out_valid;
    logic                     out_ready;
    logic [NWORDS*WIDTH-1:0]  out_sum;
    logic                     out_cout;
`ifdef ADDERC_MP_SEQ_OVF_EN
    logic                     out_ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
`ifdef ADDERC_MP_SEQ_OVF_EN
        input  out_ovf,
`endif
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
`ifdef ADDERC_MP_SEQ_OVF_EN
        output out_ovf,
`endif
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/adderc_mp_seq.sv
// Multi-precision add/sub sequencer built around one narrow adderc instance.
// Wide operands are pushed through the adder one WIDTH-bit chunk per step,
// least significant word first, with each chunk's carry chained into the next.
// Optional feature macro: ADDERC_MP_SEQ_OVF_EN adds the signed-overflow output out_ovf.

// Narrow adder: out = a + (sub_nadd ? ~b : b) + cin, with the carry on cout.
module adderc #(
    parameter int WIDTH      = 16,
    parameter int IS_REG_OUT = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             enable,
    input  logic             sub_nadd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             cout
);
    logic [WIDTH:0] raw;

    // Full-width sum with one extra bit for the carry.
    always_comb begin
        raw = {1'b0, a} + {1'b0, (sub_nadd ? ~b : b)} + {{WIDTH{1'b0}}, cin};
    end

    generate
        if (IS_REG_OUT != 0) begin : g_reg
            // Registered result, updated every enabled cycle.
            always_ff @(posedge clk) begin
                if (srst) begin
                    out  <= '0;
                    cout <= 1'b0;
                end else if (enable) begin
                    out  <= raw[WIDTH-1:0];
                    cout <= raw[WIDTH];
                end
            end
        end else begin : g_comb
            // Combinational result straight from the sum.
            always_comb begin
                out  = raw[WIDTH-1:0];
                cout = raw[WIDTH];
            end
        end
    endgenerate
endmodule

module adderc_mp_seq #(
    parameter int WIDTH      = 16,
    parameter int NWORDS     = 4,
    parameter int IS_REG_OUT = 1
) (
    input logic            clk,
    input logic            srst,
    adderc_mp_seq_if.slave bus
);
    localparam int TOTAL = NWORDS * WIDTH;
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [TOTAL-1:0] a_reg;
    logic [TOTAL-1:0] b_reg;
    logic [TOTAL-1:0] sum_reg;
    logic             sub_reg;
    logic             carry;
    logic             cout_reg;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             write_word;
    logic             last_word;
    logic [WIDTH-1:0] chunk_a;
    logic [WIDTH-1:0] chunk_b;
    logic [WIDTH-1:0] chunk_sum;
    logic             chunk_cout;
`ifdef ADDERC_MP_SEQ_OVF_EN
    logic             ovf_reg;
`endif

    // Select the operand chunk currently being worked on.
    always_comb begin
        chunk_a = a_reg[int'(idx)*WIDTH +: WIDTH];
        chunk_b = b_reg[int'(idx)*WIDTH +: WIDTH];
    end

    adderc #(
        .WIDTH      (WIDTH),
        .IS_REG_OUT (IS_REG_OUT)
    ) u_adderc (
        .clk      (clk),
        .srst     (srst),
        .enable   (1'b1),
        .sub_nadd (sub_reg),
        .a        (chunk_a),
        .b        (chunk_b),
        .cin      (carry),
        .out      (chunk_sum),
        .cout     (chunk_cout)
    );

    assign last_word = (idx == LAST_IDX);

    // State register; reset always returns to IDLE and abandons any operation.
    always_ff @(posedge clk) begin
        if (srst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the accept and word-write strobes for the datapath.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        write_word = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (IS_REG_OUT != 0) begin
                    next_state = WAIT;
                end else begin
                    write_word = 1'b1;
                    next_state = last_word ? DONE : ISSUE;
                end
            end
            WAIT: begin
                write_word = 1'b1;
                next_state = last_word ? DONE : ISSUE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture the request, then collect result words and chain the carry.
    always_ff @(posedge clk) begin
        if (srst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            sub_reg  <= 1'b0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            idx      <= '0;
`ifdef ADDERC_MP_SEQ_OVF_EN
            ovf_reg  <= 1'b0;
`endif
        end else if (accept) begin
            a_reg    <= bus.in_a;
            b_reg    <= bus.in_b;
            sub_reg  <= bus.in_sub;
            carry    <= bus.in_cin;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            idx      <= '0;
`ifdef ADDERC_MP_SEQ_OVF_EN
            ovf_reg  <= 1'b0;
`endif
        end else if (write_word) begin
            sum_reg[int'(idx)*WIDTH +: WIDTH] <= chunk_sum;
            carry <= chunk_cout;
            if (last_word) begin
                cout_reg <= chunk_cout;
`ifdef ADDERC_MP_SEQ_OVF_EN
                ovf_reg  <= (a_reg[TOTAL-1] == (sub_reg ? ~b_reg[TOTAL-1] : b_reg[TOTAL-1]))
                            & (chunk_sum[WIDTH-1] != a_reg[TOTAL-1]);
`endif
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Outputs are masked outside DONE so a partial result is never visible.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_sum   = (state == DONE) ? sum_reg : '0;
        bus.out_cout  = (state == DONE) ? cout_reg : 1'b0;
`ifdef ADDERC_MP_SEQ_OVF_EN
        bus.out_ovf   = (state == DONE) ? ovf_reg : 1'b0;
`endif
    end
endmodule

// File: tb/tb_adderc_mp_seq.sv
// Bench for adderc_mp_seq: runs a combinational-adder instance (dut0) and a
// registered-adder instance (dut1) side by side on shared stimulus.
// Overflow checks are compiled in only with ADDERC_MP_SEQ_OVF_EN.
module tb_adderc_mp_seq;
    logic        clk;
    logic        srst0;
    logic        srst1;
    logic        in_valid;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_sub;
    logic        in_cin;
    logic        out_ready;

    logic        ready_o [2];
    logic        valid_o [2];
    logic [63:0] sum_o   [2];
    logic        cout_o  [2];
`ifdef ADDERC_MP_SEQ_OVF_EN
    logic        ovf_o   [2];
`endif

    int tests_run;
    int tests_failed;

    adderc_mp_seq_if #(.WIDTH(16), .NWORDS(4)) bus0 ();
    adderc_mp_seq_if #(.WIDTH(16), .NWORDS(4)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_a      = in_a;
    assign bus0.in_b      = in_b;
    assign bus0.in_sub    = in_sub;
    assign bus0.in_cin    = in_cin;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_a      = in_a;
    assign bus1.in_b      = in_b;
    assign bus1.in_sub    = in_sub;
    assign bus1.in_cin    = in_cin;
    assign bus1.out_ready = out_ready;

    assign ready_o[0] = bus0.in_ready;
    assign valid_o[0] = bus0.out_valid;
    assign sum_o[0]   = bus0.out_sum;
    assign cout_o[0]  = bus0.out_cout;
    assign ready_o[1] = bus1.in_ready;
    assign valid_o[1] = bus1.out_valid;
    assign sum_o[1]   = bus1.out_sum;
    assign cout_o[1]  = bus1.out_cout;
`ifdef ADDERC_MP_SEQ_OVF_EN
    assign ovf_o[0]   = bus0.out_ovf;
    assign ovf_o[1]   = bus1.out_ovf;
`endif

    adderc_mp_seq #(.WIDTH(16), .NWORDS(4), .IS_REG_OUT(0)) dut0 (
        .clk  (clk),
        .srst (srst0),
        .bus  (bus0)
    );

    adderc_mp_seq #(.WIDTH(16), .NWORDS(4), .IS_REG_OUT(1)) dut1 (
        .clk  (clk),
        .srst (srst1),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Present a request at a falling edge and withdraw it one cycle later.
    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic sub, input logic cin);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count cycles since the accept edge until each instance raises out_valid (-1 = never).
    task automatic wait_done(output int lat0, output int lat1);
        lat0 = -1;
        lat1 = -1;
        for (int c = 0; c < 40; c++) begin
            if (lat0 < 0 && valid_o[0]) lat0 = c;
            if (lat1 < 0 && valid_o[1]) lat1 = c;
            if (lat0 >= 0 && lat1 >= 0) break;
            @(negedge clk);
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        srst0 = 1'b1;
        srst1 = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (ready_o[d] !== 1'b1 || valid_o[d] !== 1'b0 || sum_o[d] !== 64'h0 || cout_o[d] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset dut%0d: ready=%b valid=%b sum=%h cout=%b, expected 1 0 0 0",
                         d, ready_o[d], valid_o[d], sum_o[d], cout_o[d]);
            end
`ifdef ADDERC_MP_SEQ_OVF_EN
            tests_run++;
            if (ovf_o[d] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_ovf dut%0d: got %b expected 0", d, ovf_o[d]);
            end
`endif
        end
        srst0 = 1'b0;
        srst1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_ops();
        logic [63:0] ta [3];
        logic [63:0] tb [3];
        logic        tsub [3];
        logic        tcin [3];
        logic [63:0] es [3];
        logic        ec [3];
        int          lat [2];
        int          l0;
        int          l1;
        ta[0] = 64'h0000_0000_0000_FFFF; tb[0] = 64'h1; tsub[0] = 1'b0; tcin[0] = 1'b0;
        es[0] = 64'h0000_0000_0001_0000; ec[0] = 1'b0;
        ta[1] = 64'h0;                   tb[1] = 64'h1; tsub[1] = 1'b1; tcin[1] = 1'b1;
        es[1] = 64'hFFFF_FFFF_FFFF_FFFF; ec[1] = 1'b0;
        ta[2] = 64'hFFFF_FFFF_FFFF_FFFF; tb[2] = 64'hFFFF_FFFF_FFFF_FFFF; tsub[2] = 1'b0; tcin[2] = 1'b0;
        es[2] = 64'hFFFF_FFFF_FFFF_FFFE; ec[2] = 1'b1;
        for (int v = 0; v < 3; v++) begin
            start_op(ta[v], tb[v], tsub[v], tcin[v]);
            wait_done(l0, l1);
            lat[0] = l0;
            lat[1] = l1;
            for (int d = 0; d < 2; d++) begin
                tests_run++;
                if (lat[d] !== 4 * (d + 1)) begin
                    tests_failed++;
                    $display("[TB] FAIL basic%0d_latency dut%0d: got %0d expected %0d", v, d, lat[d], 4 * (d + 1));
                end
                tests_run++;
                if (sum_o[d] !== es[v] || cout_o[d] !== ec[v]) begin
                    tests_failed++;
                    $display("[TB] FAIL basic%0d_result dut%0d: sum=%h cout=%b expected sum=%h cout=%b",
                             v, d, sum_o[d], cout_o[d], es[v], ec[v]);
                end
            end
            handoff();
            for (int d = 0; d < 2; d++) begin
                tests_run++;
                if (valid_o[d] !== 1'b0 || ready_o[d] !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL basic%0d_handoff dut%0d: valid=%b ready=%b expected 0 1",
                             v, d, valid_o[d], ready_o[d]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat [2];
        int l0;
        int l1;
        @(negedge clk);
        in_a     = 64'd100;
        in_b     = 64'd23;
        in_sub   = 1'b0;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_a = 64'h1234_5678_9ABC_DEF0;
        in_b = 64'h1111_1111_1111_1111;
        wait_done(l0, l1);
        for (int i = 0; i < 5; i++) begin
            for (int d = 0; d < 2; d++) begin
                tests_run++;
                if (valid_o[d] !== 1'b1 || ready_o[d] !== 1'b0 || sum_o[d] !== 64'd123 || cout_o[d] !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL hold%0d dut%0d: valid=%b ready=%b sum=%h cout=%b expected 1 0 %h 0",
                             i, d, valid_o[d], ready_o[d], sum_o[d], cout_o[d], 64'd123);
                end
            end
            @(negedge clk);
        end
        handoff();
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (valid_o[d] !== 1'b0 || ready_o[d] !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL b2b_handoff dut%0d: valid=%b ready=%b expected 0 1", d, valid_o[d], ready_o[d]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(l0, l1);
        lat[0] = l0;
        lat[1] = l1;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (lat[d] !== 4 * (d + 1)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_latency dut%0d: got %0d expected %0d", d, lat[d], 4 * (d + 1));
            end
            tests_run++;
            if (sum_o[d] !== 64'h2345_6789_ABCD_F001 || cout_o[d] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL b2b_result dut%0d: sum=%h cout=%b expected sum=%h cout=0",
                         d, sum_o[d], cout_o[d], 64'h2345_6789_ABCD_F001);
            end
        end
        handoff();
    endtask

    task automatic test_srst_abort();
        int l0;
        int l1;
        int seen_valid;
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        srst0 = 1'b1;
        @(negedge clk);
        srst0 = 1'b0;
        tests_run++;
        if (ready_o[0] !== 1'b1 || valid_o[0] !== 1'b0 || sum_o[0] !== 64'h0 || cout_o[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort dut0: ready=%b valid=%b sum=%h cout=%b expected 1 0 0 0",
                     ready_o[0], valid_o[0], sum_o[0], cout_o[0]);
        end
        tests_run++;
        if (ready_o[1] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_isolation dut1: ready=%b expected 0", ready_o[1]);
        end
        @(negedge clk);
        srst1 = 1'b1;
        @(negedge clk);
        srst1 = 1'b0;
        tests_run++;
        if (ready_o[1] !== 1'b1 || valid_o[1] !== 1'b0 || sum_o[1] !== 64'h0 || cout_o[1] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort dut1: ready=%b valid=%b sum=%h cout=%b expected 1 0 0 0",
                     ready_o[1], valid_o[1], sum_o[1], cout_o[1]);
        end
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_o[0] || valid_o[1]) seen_valid++;
        end
        tests_run++;
        if (seen_valid !== 0) begin
            tests_failed++;
            $display("[TB] FAIL abort_no_result: valid seen %0d cycles, expected 0", seen_valid);
        end
        start_op(64'd3, 64'd4, 1'b0, 1'b0);
        wait_done(l0, l1);
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (valid_o[d] !== 1'b1 || sum_o[d] !== 64'd7 || cout_o[d] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL after_abort dut%0d: valid=%b sum=%h cout=%b expected 1 %h 0",
                         d, valid_o[d], sum_o[d], cout_o[d], 64'd7);
            end
        end
        handoff();
    endtask

    task automatic test_overflow();
        logic [63:0] ta [2];
        logic [63:0] tb [2];
        logic        tsub [2];
        logic        tcin [2];
        logic [63:0] es [2];
        logic        ec [2];
        logic        eo [2];
        int          l0;
        int          l1;
        ta[0] = 64'h7FFF_FFFF_FFFF_FFFF; tb[0] = 64'h1; tsub[0] = 1'b0; tcin[0] = 1'b0;
        es[0] = 64'h8000_0000_0000_0000; ec[0] = 1'b0; eo[0] = 1'b1;
        ta[1] = 64'd5; tb[1] = 64'd3; tsub[1] = 1'b1; tcin[1] = 1'b1;
        es[1] = 64'd2; ec[1] = 1'b1; eo[1] = 1'b0;
        for (int v = 0; v < 2; v++) begin
            start_op(ta[v], tb[v], tsub[v], tcin[v]);
            wait_done(l0, l1);
            for (int d = 0; d < 2; d++) begin
                tests_run++;
                if (valid_o[d] !== 1'b1 || sum_o[d] !== es[v] || cout_o[d] !== ec[v]) begin
                    tests_failed++;
                    $display("[TB] FAIL ovf%0d_result dut%0d: valid=%b sum=%h cout=%b expected 1 %h %b",
                             v, d, valid_o[d], sum_o[d], cout_o[d], es[v], ec[v]);
                end
`ifdef ADDERC_MP_SEQ_OVF_EN
                tests_run++;
                if (ovf_o[d] !== eo[v]) begin
                    tests_failed++;
                    $display("[TB] FAIL ovf%0d_flag dut%0d: got %b expected %b", v, d, ovf_o[d], eo[v]);
                end
`else
                if (eo[v] === 1'bx) $display("[TB] note: overflow flag undefined");
`endif
            end
            handoff();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        srst0        = 1'b1;
        srst1        = 1'b1;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_sub       = 1'b0;
        in_cin       = 1'b0;
        out_ready    = 1'b0;
        test_reset();
        test_basic_ops();
        test_back_to_back();
        test_srst_abort();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
